// File: rtl/stage_issue.sv
// Issue stage: operand resolution with prioritised forwarding, hazard stall,
// jump-shadow discard and a single output register toward execute.
module stage_issue #(
  parameter int XLEN   = 32,
  parameter int AW     = 4,
  parameter int NFWD   = 2,
  parameter int PW     = 16,
  parameter int SHADOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              instr_valid,
  input  logic [AW-1:0]     src_a_addr,
  input  logic [AW-1:0]     src_b_addr,
  input  logic              src_a_used,
  input  logic              src_b_used,
  input  logic [XLEN-1:0]   rf_a_data,
  input  logic [XLEN-1:0]   rf_b_data,
  input  logic [AW-1:0]     dest_in,
  input  logic [PW-1:0]     payload_in,
  input  logic              is_jump,
  input  logic [NFWD-1:0]   fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic              stall_in,
  output logic              stall,
  output logic              discard,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   op_a,
  output logic [XLEN-1:0]   op_b,
  output logic [AW-1:0]     dest,
  output logic [PW-1:0]     payload,
  output logic              out_valid,
  output logic              jump
);

  // A zero-length shadow still needs a one-bit counter to stay legal.
  localparam int CW = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;
  localparam logic SH_EN = (SHADOW > 0);

  logic [CW-1:0]   cnt;
  logic            a_hit, a_ok, b_hit, b_ok;
  logic [XLEN-1:0] a_fwd, b_fwd;
  logic [XLEN-1:0] a_res, b_res;
  logic            hazard, cnt_zero;
  logic            accept, drop;

  // Walk ports high to low so the lowest-index match wins.
  always_comb begin
    a_hit = 1'b0;
    a_ok  = 1'b1;
    a_fwd = '0;
    b_hit = 1'b0;
    b_ok  = 1'b1;
    b_fwd = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (src_a_addr != '0 &&
          fwd_addr[i*AW +: AW] == src_a_addr) begin
        a_hit = 1'b1;
        a_ok  = fwd_valid[i];
        a_fwd = fwd_data[i*XLEN +: XLEN];
      end
      if (src_b_addr != '0 &&
          fwd_addr[i*AW +: AW] == src_b_addr) begin
        b_hit = 1'b1;
        b_ok  = fwd_valid[i];
        b_fwd = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    a_res = rf_a_data;
    if (src_a_addr == '0) a_res = '0;
    else if (a_hit)       a_res = a_fwd;
    b_res = rf_b_data;
    if (src_b_addr == '0) b_res = '0;
    else if (b_hit)       b_res = b_fwd;
  end

  assign hazard   = (src_a_used & a_hit & ~a_ok) |
                    (src_b_used & b_hit & ~b_ok);
  assign cnt_zero = (cnt == '0);
  assign accept   = instr_valid & ~stall_in &
                    ~hazard & cnt_zero;
  assign drop     = instr_valid & ~stall_in & ~cnt_zero;
  assign stall    = stall_in | ~instr_valid |
                    (hazard & cnt_zero);
  assign discard  = (accept & is_jump & SH_EN) | ~cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept & is_jump & SH_EN) begin
      cnt <= CW'(SHADOW);
    end else if (drop) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      dest      <= '0;
      payload   <= '0;
      out_valid <= 1'b0;
      jump      <= 1'b0;
    end else if (!stall_in) begin
      if (accept) begin
        pc        <= pc_in;
        op_a      <= a_res;
        op_b      <= b_res;
        dest      <= dest_in;
        payload   <= payload_in;
        out_valid <= 1'b1;
        jump      <= is_jump;
      end else begin
        dest      <= '0;
        payload   <= '0;
        out_valid <= 1'b0;
        jump      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_issue.sv
// Directed bench for stage_issue: forwarding, hazards, shadow, stall, reset.
module tb_stage_issue;

  localparam int XLEN = 32;
  localparam int AW   = 4;
  localparam int NFWD = 2;
  localparam int PW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   pc_in;
  logic              instr_valid;
  logic [AW-1:0]     src_a_addr, src_b_addr;
  logic              src_a_used, src_b_used;
  logic [XLEN-1:0]   rf_a_data, rf_b_data;
  logic [AW-1:0]     dest_in;
  logic [PW-1:0]     payload_in;
  logic              is_jump;
  logic [NFWD-1:0]   fwd_valid;
  logic [NFWD*AW-1:0] fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic              stall_in;
  logic              stall, discard;
  logic [XLEN-1:0]   pc, op_a, op_b;
  logic [AW-1:0]     dest;
  logic [PW-1:0]     payload;
  logic              out_valid, jump;

  int vectors = 0;
  int miscompares = 0;

  stage_issue #(
    .XLEN(XLEN), .AW(AW), .NFWD(NFWD),
    .PW(PW), .SHADOW(2)
  ) dut (
    .clk(clk), .rst(rst),
    .pc_in(pc_in), .instr_valid(instr_valid),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .src_a_used(src_a_used), .src_b_used(src_b_used),
    .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .dest_in(dest_in), .payload_in(payload_in),
    .is_jump(is_jump),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .stall_in(stall_in),
    .stall(stall), .discard(discard),
    .pc(pc), .op_a(op_a), .op_b(op_b),
    .dest(dest), .payload(payload),
    .out_valid(out_valid), .jump(jump)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(
    input logic [XLEN-1:0] p,
    input logic [AW-1:0] a, input logic au,
    input logic [AW-1:0] b, input logic bu,
    input logic [AW-1:0] d, input logic [PW-1:0] pl,
    input logic j
  );
    instr_valid = 1'b1;
    pc_in = p;
    src_a_addr = a; src_a_used = au;
    src_b_addr = b; src_b_used = bu;
    dest_in = d; payload_in = pl; is_jump = j;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; stall_in = 1'b0;
    pc_in = '0; src_a_addr = '0; src_b_addr = '0;
    src_a_used = 1'b0; src_b_used = 1'b0;
    rf_a_data = '0; rf_b_data = '0; dest_in = '0;
    payload_in = '0; is_jump = 1'b0;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    #3;
    vectors++;
    if (out_valid !== 1'b0 || jump !== 1'b0 || pc !== '0 ||
        op_a !== '0 || op_b !== '0 || dest !== '0 ||
        payload !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got v%b j%b pc%h a%h b%h d%h p%h exp all 0",
               out_valid, jump, pc, op_a, op_b, dest, payload);
    end
    vectors++;
    if (dut.cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d exp 0", dut.cnt);
    end
    vectors++;
    if (stall !== 1'b1 || discard !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_comb: got stall%b disc%b exp 1 0", stall, discard);
    end
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_fwd_priority();
    set_instr(32'h100, 4'd3, 1'b1, 4'd0, 1'b0, 4'd1, 16'h1111, 1'b0);
    rf_a_data = 32'h11; rf_b_data = 32'h22;
    fwd_valid = 2'b11;
    fwd_addr = {4'd3, 4'd3};
    fwd_data = {32'hBB, 32'hAA};
    #1;
    vectors++;
    if (stall !== 1'b0 || discard !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_comb: got stall%b disc%b exp 0 0", stall, discard);
    end
    cycle();
    vectors++;
    if (op_a !== 32'hAA || op_b !== 32'h0 || out_valid !== 1'b1 ||
        pc !== 32'h100 || dest !== 4'd1 || payload !== 16'h1111) begin
      miscompares++;
      $display("FAIL prio_port0: got a%h b%h v%b pc%h d%h p%h exp aa 0 1 100 1 1111",
               op_a, op_b, out_valid, pc, dest, payload);
    end
    set_instr(32'h104, 4'd3, 1'b1, 4'd6, 1'b1, 4'd2, 16'h2222, 1'b0);
    rf_a_data = 32'h33; rf_b_data = 32'h66;
    fwd_valid = 2'b11;
    fwd_addr = {4'd3, 4'd4};
    fwd_data = {32'hBB, 32'hAA};
    cycle();
    vectors++;
    if (op_a !== 32'hBB || op_b !== 32'h66 || out_valid !== 1'b1 ||
        pc !== 32'h104) begin
      miscompares++;
      $display("FAIL prio_port1_rf: got a%h b%h v%b pc%h exp bb 66 1 104",
               op_a, op_b, out_valid, pc);
    end
  endtask

  task automatic test_hazard();
    set_instr(32'h108, 4'd0, 1'b0, 4'd5, 1'b1, 4'd7, 16'h7777, 1'b0);
    rf_b_data = 32'h55;
    fwd_valid = 2'b10;
    fwd_addr = {4'd5, 4'd5};
    fwd_data = {32'h77, 32'h0};
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_stall: got %b exp 1", stall);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b0 || dest !== '0 || payload !== '0 ||
        pc !== 32'h104 || op_b !== 32'h66) begin
      miscompares++;
      $display("FAIL hazard_bubble: got v%b d%h p%h pc%h b%h exp 0 0 0 104 66",
               out_valid, dest, payload, pc, op_b);
    end
    fwd_valid = 2'b11;
    fwd_data = {32'h77, 32'h1234};
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL hazard_clear: got %b exp 0", stall);
    end
    cycle();
    vectors++;
    if (op_b !== 32'h1234 || out_valid !== 1'b1 || dest !== 4'd7) begin
      miscompares++;
      $display("FAIL hazard_accept: got b%h v%b d%h exp 1234 1 7",
               op_b, out_valid, dest);
    end
  endtask

  task automatic test_zero_unused();
    set_instr(32'h10C, 4'd0, 1'b1, 4'd7, 1'b0, 4'd3, 16'h3333, 1'b0);
    rf_a_data = 32'h55; rf_b_data = 32'h44;
    fwd_valid = 2'b01;
    fwd_addr = {4'd7, 4'd0};
    fwd_data = {32'h99, 32'hFF};
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL unused_nostall: got %b exp 0", stall);
    end
    cycle();
    vectors++;
    if (op_a !== 32'h0 || op_b !== 32'h99 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_reg: got a%h b%h v%b exp 0 99 1",
               op_a, op_b, out_valid);
    end
  endtask

  task automatic test_jump_shadow();
    set_instr(32'h200, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 16'hA0, 1'b1);
    #1;
    vectors++;
    if (discard !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_disc: got disc%b stall%b exp 1 0", discard, stall);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || jump !== 1'b1 || pc !== 32'h200) begin
      miscompares++;
      $display("FAIL jump_accept: got v%b j%b pc%h exp 1 1 200",
               out_valid, jump, pc);
    end
    instr_valid = 1'b0;
    cycle();
    vectors++;
    if (dut.cnt !== 2'd2 || discard !== 1'b1) begin
      miscompares++;
      $display("FAIL shadow_idle: got cnt%0d disc%b exp 2 1", dut.cnt, discard);
    end
    for (int k = 0; k < 2; k++) begin
      set_instr(32'h204 + 4 * k, 4'd0, 1'b0, 4'd0, 1'b0,
                4'd2, 16'hB0, 1'b0);
      #1;
      vectors++;
      if (discard !== 1'b1 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL shadow_disc%0d: got disc%b stall%b exp 1 0",
                 k, discard, stall);
      end
      cycle();
      vectors++;
      if (out_valid !== 1'b0 || dest !== '0 || jump !== 1'b0 ||
          pc !== 32'h200) begin
        miscompares++;
        $display("FAIL shadow_bubble%0d: got v%b d%h j%b pc%h exp 0 0 0 200",
                 k, out_valid, dest, jump, pc);
      end
    end
    set_instr(32'h20C, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 16'hC0, 1'b0);
    #1;
    vectors++;
    if (discard !== 1'b0) begin
      miscompares++;
      $display("FAIL shadow_end: got disc%b exp 0", discard);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || pc !== 32'h20C || dest !== 4'd3) begin
      miscompares++;
      $display("FAIL shadow_third: got v%b pc%h d%h exp 1 20c 3",
               out_valid, pc, dest);
    end
  endtask

  task automatic test_stall_hold();
    set_instr(32'h300, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 16'hABCD, 1'b0);
    cycle();
    set_instr(32'h304, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 16'h4444, 1'b0);
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (stall !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_stall%0d: got %b exp 1", k, stall);
      end
      cycle();
      vectors++;
      if (pc !== 32'h300 || out_valid !== 1'b1 || dest !== 4'd9 ||
          payload !== 16'hABCD) begin
        miscompares++;
        $display("FAIL hold_regs%0d: got pc%h v%b d%h p%h exp 300 1 9 abcd",
                 k, pc, out_valid, dest, payload);
      end
    end
    stall_in = 1'b0;
    cycle();
    vectors++;
    if (pc !== 32'h304 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: got pc%h v%b exp 304 1", pc, out_valid);
    end
  endtask

  task automatic test_reset_shadow();
    set_instr(32'h310, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 16'h5, 1'b1);
    cycle();
    instr_valid = 1'b0;
    vectors++;
    if (dut.cnt !== 2'd2) begin
      miscompares++;
      $display("FAIL pre_rst_cnt: got %0d exp 2", dut.cnt);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (dut.cnt !== '0 || out_valid !== 1'b0 || pc !== '0 ||
        discard !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_shadow: got cnt%0d v%b pc%h disc%b exp 0 0 0 0",
               dut.cnt, out_valid, pc, discard);
    end
    #1;
    rst = 1'b0;
    set_instr(32'h400, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 16'h6, 1'b0);
    #1;
    vectors++;
    if (stall !== 1'b0 || discard !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst_comb: got stall%b disc%b exp 0 0", stall, discard);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || pc !== 32'h400 || dest !== 4'd6) begin
      miscompares++;
      $display("FAIL post_rst_accept: got v%b pc%h d%h exp 1 400 6",
               out_valid, pc, dest);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_hazard();
    test_zero_unused();
    test_jump_shadow();
    test_stall_hold();
    test_reset_shadow();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_issue.md
STAGE_ISSUE -- requirements
Module: stage_issue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data and PC width.
REQ-002 The block SHALL have parameter AW, default 4, meaning the register address width; address 0 is the hardwired-zero register.
REQ-003 The block SHALL have parameter NFWD, default 2, meaning the number of forwarding ports; port 0 has the highest priority (youngest producer).
REQ-004 The block SHALL have parameter PW, default 16, meaning the width of the opaque decoded-control payload.
REQ-005 The block SHALL have parameter SHADOW, default 1, meaning the number of instructions discarded after an accepted jump; 0 disables discarding.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, the clock; rst input 1, the reset.
REQ-007 Inputs SHALL be: pc_in XLEN; instr_valid 1; src_a_addr AW; src_b_addr AW; src_a_used 1; src_b_used 1; rf_a_data XLEN; rf_b_data XLEN; dest_in AW; payload_in PW; is_jump 1.
REQ-008 Forwarding inputs SHALL be: fwd_valid NFWD; fwd_addr NFWD*AW; fwd_data NFWD*XLEN; port i occupies slice i in each vector.
REQ-009 Downstream input SHALL be stall_in 1, where 1 means the next stage cannot take a new entry.
REQ-010 Upstream outputs SHALL be: stall 1, meaning the current instruction is not consumed; discard 1, meaning the current or next fetched instruction lies in a jump shadow.
REQ-011 Registered outputs SHALL be: pc XLEN; op_a XLEN; op_b XLEN; dest AW; payload PW; out_valid 1; jump 1.

Function
REQ-012 A forwarding port SHALL match a source only when fwd_addr[i] equals that source address and the address is nonzero.
REQ-013 Operand resolution SHALL follow this order:
- source address 0 resolves to value 0;
- otherwise, the lowest-index matching port supplies fwd_data;
- otherwise, rf data is used.
REQ-014 A hazard SHALL exist when a used source's lowest-index matching port has fwd_valid=0; an unused source never causes a hazard.
REQ-015 The shadow counter SHALL be named cnt, be $clog2(SHADOW+1) bits wide, and reset to 0.
REQ-016 The accept condition SHALL be: accept = instr_valid & ~stall_in & ~hazard & (cnt==0).
REQ-017 The drop condition SHALL be: drop = instr_valid & ~stall_in & (cnt!=0); a dropped instruction is consumed regardless of hazard.
REQ-018 The stall output SHALL be: stall = stall_in | ~instr_valid | (hazard & cnt==0); it is combinational.
REQ-019 On accept, the output register SHALL load pc_in, the resolved operands, dest_in, payload_in, and jump<=is_jump, and set out_valid<=1 on the next clk edge (latency one cycle).
REQ-020 When stall_in=0 and the cycle is not an accept, the block SHALL emit a bubble: out_valid<=0, dest<=0, payload<=0, jump<=0; pc, op_a and op_b hold their values.
REQ-021 When stall_in=1, all registered outputs SHALL hold their values.
REQ-022 An accept with is_jump=1 and SHADOW>0 SHALL set cnt<=SHADOW.
REQ-023 A drop SHALL decrement cnt by 1; cnt SHALL never wrap below 0.
REQ-024 The discard output SHALL be: discard = (accept & is_jump & SHADOW>0) | (cnt!=0).
REQ-025 With SHADOW=0, cnt SHALL remain 0 and discard SHALL remain 0.
REQ-026 When instr_valid=0 or stall_in=1, cnt SHALL hold its value (shadow counts instructions, not cycles).
REQ-027 When several ports match the same address, only the lowest-index port SHALL decide both the hazard and the data, whatever the state of the higher-index ports.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force: out_valid=0, jump=0, dest=0, payload=0, pc=0, op_a=0, op_b=0, cnt=0.
REQ-029 A reset asserted mid-shadow SHALL cancel the shadow; the first instruction after reset release SHALL be eligible for accept.
REQ-030 After reset, the stall and discard outputs SHALL reflect inputs combinationally, with cnt=0.

Verification
REQ-031 The bench SHALL cover forwarding priority: src_a=3 used, port0 addr3 valid data 0xAA, port1 addr3 valid data 0xBB -> next cycle op_a=0xAA, out_valid=1.
REQ-032 The bench SHALL cover a hazard stall: src_b=5 used, port0 addr5 fwd_valid=0, then fwd_valid=1 with data 0x1234 -> stall=1 and a bubble (dest=0, out_valid=0) in the first cycle, then accept with op_b=0x1234.
REQ-033 The bench SHALL cover the zero register and unused sources:
- src_a=0 with port0 addr0 data 0xFF -> op_a=0;
- src_b used=0 matching an invalid port -> no stall.
REQ-034 The bench SHALL cover the jump shadow with SHADOW=2: accept a jump, then feed three valid instructions with stall_in=0 -> discard=1 for the jump cycle and the next two, two bubbles, the third instruction accepted.
REQ-035 The bench SHALL cover downstream stall and reset: stall_in=1 for 3 cycles with valid input -> outputs hold and stall=1; rst pulsed with cnt=2 -> cnt=0, out_valid=0, and the next valid instruction is accepted.
